// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: bus register map,
// FSM state encoding and CAUSE/CTRL bit positions.
package interrupt_controller_pkg;

  localparam logic [1:0] ADDR_PEND  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_CAUSE = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int unsigned CAUSE_VALID_BIT = 31;
  localparam int unsigned CTRL_GIE_BIT    = 0;
  localparam int unsigned CTRL_INSVC_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-wins priority encoder for the active interrupt vector.
module irq_priority_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] vec,
  output logic [2:0]   idx,
  output logic         any
);

  // Scan upward; the first set bit found is latched and later bits ignored.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !any) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detected pending bits, per-source mask,
// global enable, and a request/service handshake with the CPU.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Address,
  input  logic [31:0]      Write_data,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic [31:0]      Read_data,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             irq_ack,
  input  logic             irq_eret,
  output logic             IRQ
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] mask_q;
  logic             gie_q;
  logic             edge_en_q;
  logic             cause_valid_q;
  logic [2:0]       cause_idx_q;

  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] wr_clr;
  logic [N_SRC-1:0] svc_clr;
  logic [2:0]       win_idx;
  logic             win_any;
  logic             take_ack;
  logic             unused_wdata;

  assign unused_wdata = ^Write_data[31:N_SRC];

  assign active = pend_q & mask_q;

  irq_priority_enc #(.N(N_SRC)) u_enc (
    .vec (active),
    .idx (win_idx),
    .any (win_any)
  );

  // edge_en_q stays low for the first clock after reset so lines that were
  // already high across the release only load src_q and raise no edge.
  assign edges  = irq_src & ~src_q & {N_SRC{edge_en_q}};
  assign wr_clr = (MemWrite && Address == ADDR_PEND) ? Write_data[N_SRC-1:0] : '0;

  // One-hot clear of the source being acknowledged this cycle.
  always_comb begin
    svc_clr = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      svc_clr[i] = take_ack && (win_idx == 3'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state; an ack only counts in REQ with something still active.
  always_comb begin
    state_d  = state_q;
    take_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gie_q && win_any) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (irq_ack && win_any) begin
          state_d  = ST_SERVICE;
          take_ack = 1'b1;
        end else if (!gie_q || !win_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (irq_eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge detector and pending bits; a new edge overrides any clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q     <= '0;
      edge_en_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      src_q     <= irq_src;
      edge_en_q <= 1'b1;
      pend_q    <= (pend_q & ~wr_clr & ~svc_clr) | edges;
    end
  end

  // Bus-writable configuration: mask and global enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      gie_q  <= 1'b0;
    end else if (MemWrite) begin
      if (Address == ADDR_MASK) mask_q <= Write_data[N_SRC-1:0];
      if (Address == ADDR_CTRL) gie_q  <= Write_data[CTRL_GIE_BIT];
    end
  end

  // CAUSE capture on acknowledge; valid drops on return from handler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_valid_q <= 1'b0;
      cause_idx_q   <= '0;
    end else if (take_ack) begin
      cause_valid_q <= 1'b1;
      cause_idx_q   <= win_idx;
    end else if (state_q == ST_SERVICE && irq_eret) begin
      cause_valid_q <= 1'b0;
    end
  end

  // Combinational read mux, zero outside MemRead and in unused bits.
  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      case (Address)
        ADDR_PEND:  Read_data[N_SRC-1:0] = pend_q;
        ADDR_MASK:  Read_data[N_SRC-1:0] = mask_q;
        ADDR_CAUSE: begin
          Read_data[CAUSE_VALID_BIT] = cause_valid_q;
          Read_data[2:0]             = cause_idx_q;
        end
        ADDR_CTRL: begin
          Read_data[CTRL_GIE_BIT]   = gie_q;
          Read_data[CTRL_INSVC_BIT] = (state_q == ST_SERVICE);
        end
        default: Read_data = '0;
      endcase
    end
  end

  assign IRQ = (state_q == ST_REQ);

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: table-driven cycle vectors
// with a scoreboard queue, plus hand-written reset corner sequences.
`timescale 1ns/1ps
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Address;
  logic [31:0] Write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Read_data;
  logic [3:0]  irq_src;
  logic        irq_ack;
  logic        irq_eret;
  logic        IRQ;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        irq;
    logic [31:0] pend;
    logic [31:0] mask;
    logic [31:0] cause;
    logic [31:0] ctrl;
  } exp_t;

  typedef struct {
    logic [3:0]  src;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        eret;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t expq[$];

  interrupt_controller #(.N_SRC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_data  (Read_data),
    .irq_src    (irq_src),
    .irq_ack    (irq_ack),
    .irq_eret   (irq_eret),
    .IRQ        (IRQ)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(logic irq, logic [31:0] pend, logic [31:0] mask,
                              logic [31:0] cause, logic [31:0] ctrl);
    exp_t r;
    r.irq = irq; r.pend = pend; r.mask = mask; r.cause = cause; r.ctrl = ctrl;
    return r;
  endfunction

  function automatic vec_t mk(logic [3:0] src, logic wr, logic [1:0] addr,
                              logic [31:0] wdata, logic ack, logic eret, exp_t e);
    vec_t v;
    v.src = src; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ack = ack; v.eret = eret; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #0.5;
    d = Read_data;
    MemRead = 1'b0;
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic check_exp(input string tag);
    exp_t e;
    logic [31:0] d;
    if (expq.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty got none expected entry", tag);
      return;
    end
    e = expq.pop_front();
    chk({tag, " irq"}, {31'd0, IRQ}, {31'd0, e.irq});
    rd(2'd0, d); chk({tag, " pend"},  d, e.pend);
    rd(2'd1, d); chk({tag, " mask"},  d, e.mask);
    rd(2'd2, d); chk({tag, " cause"}, d, e.cause);
    rd(2'd3, d); chk({tag, " ctrl"},  d, e.ctrl);
  endtask

  // One clock: inputs already driven, expectation queued; strobes dropped after.
  task automatic step_and_check(input string tag);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    irq_ack  = 1'b0;
    irq_eret = 1'b0;
    check_exp(tag);
  endtask

  initial begin
    logic [31:0] d;

    reset = 1'b0; Address = '0; Write_data = '0; MemWrite = 1'b0; MemRead = 1'b0;
    irq_src = '0; irq_ack = 1'b0; irq_eret = 1'b0;

    //                src  wr addr wdata         ack eret   irq pend mask  cause         ctrl
    tbl.push_back(mk(4'h0, 1, 2'd1, 32'h1,        0, 0, ex(0, 32'h0, 32'h1, 32'h0,        32'h0)));
    tbl.push_back(mk(4'h0, 1, 2'd3, 32'h1,        0, 0, ex(0, 32'h0, 32'h1, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h1, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h1, 32'h1, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(1, 32'h1, 32'h1, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        1, 0, ex(0, 32'h0, 32'h1, 32'h80000000, 32'h3)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 1, ex(0, 32'h0, 32'h1, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 1, 2'd1, 32'hF,        0, 0, ex(0, 32'h0, 32'hF, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h6, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h6, 32'hF, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(1, 32'h6, 32'hF, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        1, 0, ex(0, 32'h4, 32'hF, 32'h80000001, 32'h3)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h4, 32'hF, 32'h80000001, 32'h3)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 1, ex(0, 32'h4, 32'hF, 32'h1,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(1, 32'h4, 32'hF, 32'h1,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        1, 0, ex(0, 32'h0, 32'hF, 32'h80000002, 32'h3)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 1, ex(0, 32'h0, 32'hF, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h0, 1, 2'd1, 32'h0,        0, 0, ex(0, 32'h0, 32'h0, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h8, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h8, 32'h0, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h8, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h8, 32'h0, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h8, 1, 2'd1, 32'h8,        0, 0, ex(0, 32'h8, 32'h8, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h8, 0, 2'd0, 32'h0,        0, 0, ex(1, 32'h8, 32'h8, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h8, 1, 2'd3, 32'h0,        0, 0, ex(1, 32'h8, 32'h8, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h8, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h8, 32'h8, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h8, 0, 2'd0, 32'h0,        1, 0, ex(0, 32'h8, 32'h8, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h0, 1, 2'd0, 32'h8,        0, 0, ex(0, 32'h0, 32'h8, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h1, 1, 2'd0, 32'h1,        0, 0, ex(0, 32'h1, 32'h8, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h1, 1, 2'd0, 32'h1,        0, 0, ex(0, 32'h0, 32'h8, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h0, 32'h8, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h0, 1, 2'd1, 32'h3,        0, 0, ex(0, 32'h0, 32'h3, 32'h2,        32'h0)));
    tbl.push_back(mk(4'h0, 1, 2'd3, 32'h1,        0, 0, ex(0, 32'h0, 32'h3, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h3, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h3, 32'h3, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(1, 32'h3, 32'h3, 32'h2,        32'h1)));
    tbl.push_back(mk(4'h0, 1, 2'd0, 32'h1,        1, 0, ex(0, 32'h2, 32'h3, 32'h80000000, 32'h3)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 1, ex(0, 32'h2, 32'h3, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(1, 32'h2, 32'h3, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 1, 2'd0, 32'h2,        0, 0, ex(1, 32'h0, 32'h3, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 0, ex(0, 32'h0, 32'h3, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,        0, 1, ex(0, 32'h0, 32'h3, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 1, 2'd2, 32'hFFFFFFFF, 0, 0, ex(0, 32'h0, 32'h3, 32'h0,        32'h1)));
    tbl.push_back(mk(4'h0, 1, 2'd1, 32'hFFFFFFF5, 0, 0, ex(0, 32'h0, 32'h5, 32'h0,        32'h1)));

    // Reset state while reset is held low.
    #12;
    chk("reset irq", {31'd0, IRQ}, 32'h0);
    rd(2'd0, d); chk("reset pend",  d, 32'h0);
    rd(2'd1, d); chk("reset mask",  d, 32'h0);
    rd(2'd2, d); chk("reset cause", d, 32'h0);
    rd(2'd3, d); chk("reset ctrl",  d, 32'h0);
    #10 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      irq_src    = tbl[i].src;
      MemWrite   = tbl[i].wr;
      Address    = tbl[i].addr;
      Write_data = tbl[i].wdata;
      irq_ack    = tbl[i].ack;
      irq_eret   = tbl[i].eret;
      expq.push_back(tbl[i].e);
      step_and_check($sformatf("row%0d", i));
    end

    // Read data must be zero whenever MemRead is low.
    Address = 2'd1; MemRead = 1'b0;
    #0.5;
    chk("rd_idle zero", Read_data, 32'h0);

    // Enter SERVICE on source 0 (mask 0x5, GIE 1), then reset mid-service.
    irq_src = 4'h1;
    expq.push_back(ex(0, 32'h1, 32'h5, 32'h0, 32'h1));
    step_and_check("svc edge");
    expq.push_back(ex(1, 32'h1, 32'h5, 32'h0, 32'h1));
    step_and_check("svc req");
    irq_ack = 1'b1;
    expq.push_back(ex(0, 32'h0, 32'h5, 32'h80000000, 32'h3));
    step_and_check("svc ack");

    #1 reset = 1'b0;
    #0.5;
    chk("midrst irq", {31'd0, IRQ}, 32'h0);
    rd(2'd0, d); chk("midrst pend",  d, 32'h0);
    rd(2'd1, d); chk("midrst mask",  d, 32'h0);
    rd(2'd2, d); chk("midrst cause", d, 32'h0);
    rd(2'd3, d); chk("midrst ctrl",  d, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Source held high across release must not register as an edge.
    for (int k = 0; k < 3; k++) begin
      expq.push_back(ex(0, 32'h0, 32'h0, 32'h0, 32'h0));
      step_and_check($sformatf("post_rst%0d", k));
    end
    irq_src = 4'h0;
    expq.push_back(ex(0, 32'h0, 32'h0, 32'h0, 32'h0));
    step_and_check("post_rst low");
    irq_src = 4'h1;
    expq.push_back(ex(0, 32'h1, 32'h0, 32'h0, 32'h0));
    step_and_check("post_rst edge");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
